// File: rtl/sc_key_pkg.sv
// sc_key_pkg: shared types for the second-chance key store.
//   op_e    - decoded command opcode
//   state_e - controller state
//   rsp_t   - response payload, sized for the widest supported configuration
package sc_key_pkg;

    // Upper bounds on KEY_WIDTH and $clog2(DEPTH) that rsp_t can carry.
    localparam int unsigned MAX_KEY_W = 64;
    localparam int unsigned MAX_IDX_W = 8;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_INSERT = 2'd1,
        OP_DELETE = 2'd2
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        SCAN = 2'd2
    } state_e;

    typedef struct packed {
        logic                 hit;
        logic [MAX_IDX_W-1:0] idx;
        logic                 evict;
        logic [MAX_KEY_W-1:0] evict_key;
    } rsp_t;

    // Reserved encoding 3 behaves as a lookup.
    function automatic op_e decode_op(input logic [1:0] raw);
        case (raw)
            2'd1:    decode_op = OP_INSERT;
            2'd2:    decode_op = OP_DELETE;
            default: decode_op = OP_LOOKUP;
        endcase
    endfunction

endpackage

// File: rtl/sc_key_entry.sv
// sc_key_entry: one key-store slot holding key, valid and reference bit.
//   clk, reset       - clock, synchronous active-high reset
//   write            - load wr_key, mark valid, clear ref
//   set_ref, clr_ref - reference bit update
//   invalidate       - drop the entry (valid=0, ref=0)
//   wr_key, cmp_key  - write data and compare key
//   match_c          - combinational: valid entry whose key equals cmp_key
//   ref_bit, valid, key - stored state
module sc_key_entry #(
    parameter int unsigned KEY_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    input  logic                 set_ref,
    input  logic                 clr_ref,
    input  logic                 invalidate,
    input  logic [KEY_WIDTH-1:0] wr_key,
    input  logic [KEY_WIDTH-1:0] cmp_key,
    output logic                 match_c,
    output logic                 ref_bit,
    output logic                 valid,
    output logic [KEY_WIDTH-1:0] key
);

    // Invalid entries never match, even when the stored key equals cmp_key.
    assign match_c = valid && (key == cmp_key);

    // Slot state; invalidate and write dominate the reference-bit strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid   <= 1'b0;
            ref_bit <= 1'b0;
            key     <= '0;
        end else if (invalidate) begin
            valid   <= 1'b0;
            ref_bit <= 1'b0;
        end else if (write) begin
            valid   <= 1'b1;
            ref_bit <= 1'b0;
            key     <= wr_key;
        end else if (clr_ref) begin
            ref_bit <= 1'b0;
        end else if (set_ref) begin
            ref_bit <= 1'b1;
        end
    end

endmodule

// File: rtl/sc_key_store.sv
// sc_key_store: DEPTH-entry fully associative key store with second-chance
// (clock) replacement, fronting the value RAM addressed by rsp_idx.
//   clk, reset                 - clock, synchronous active-high reset
//   cmd_valid/cmd_ready        - command handshake (ready only in IDLE)
//   cmd_op, cmd_key            - 0 lookup, 1 insert, 2 delete, 3 lookup
//   rsp_valid                  - one-cycle response pulse
//   rsp_hit, rsp_idx           - key present before command, entry touched
//   rsp_evict, rsp_evict_key   - insert displaced a valid entry and its key
//   full                       - combinational, all entries valid
module sc_key_store
    import sc_key_pkg::*;
#(
    parameter  int unsigned KEY_WIDTH = 32,
    parameter  int unsigned DEPTH     = 8,
    localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [KEY_WIDTH-1:0] cmd_key,
    output logic                 rsp_valid,
    output logic                 rsp_hit,
    output logic [IDX_W-1:0]     rsp_idx,
    output logic                 rsp_evict,
    output logic [KEY_WIDTH-1:0] rsp_evict_key,
    output logic                 full
);

    state_e               state;
    logic [IDX_W-1:0]     hand;
    logic [KEY_WIDTH-1:0] key_q;
    rsp_t                 rsp_q;

    logic [DEPTH-1:0]     match_vec;
    logic [DEPTH-1:0]     ref_vec;
    logic [DEPTH-1:0]     valid_vec;
    logic [DEPTH-1:0]     wr_vec;
    logic [DEPTH-1:0]     set_ref_vec;
    logic [DEPTH-1:0]     clr_ref_vec;
    logic [DEPTH-1:0]     inval_vec;
    logic [KEY_WIDTH-1:0] key_arr [DEPTH];

    op_e                  op;
    logic                 accept;
    logic                 hit;
    logic                 free_any;
    logic                 scan;
    logic                 scan_victim;
    logic [IDX_W-1:0]     match_idx;
    logic [IDX_W-1:0]     free_idx;
    logic [IDX_W-1:0]     hand_next;
    logic [KEY_WIDTH-1:0] wr_key;

    assign op          = decode_op(cmd_op);
    assign accept      = cmd_valid && cmd_ready;
    assign hit         = |match_vec;
    assign free_any    = ~&valid_vec;
    assign full        = &valid_vec;
    assign scan        = (state == SCAN);
    assign scan_victim = scan && !ref_vec[hand];
    assign hand_next   = (hand == IDX_W'(DEPTH - 1)) ? '0 : hand + IDX_W'(1);
    // Free-slot inserts take the live command key; scan victims take the latched one.
    assign wr_key      = scan ? key_q : cmd_key;

    // Lowest-index match and lowest-index free slot; descending walk so index 0 wins.
    always_comb begin
        match_idx = '0;
        free_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match_vec[i]) match_idx = IDX_W'(i);
            if (!valid_vec[i]) free_idx = IDX_W'(i);
        end
    end

    // Per-entry strobes; all decisions at accept use pre-accept contents.
    always_comb begin
        wr_vec      = '0;
        set_ref_vec = '0;
        clr_ref_vec = '0;
        inval_vec   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_vec[i]      = (accept && (op == OP_INSERT) && !hit && free_any &&
                              (free_idx == IDX_W'(i))) ||
                             (scan_victim && (hand == IDX_W'(i)));
            set_ref_vec[i] = accept && hit && (op != OP_DELETE) && (match_idx == IDX_W'(i));
            inval_vec[i]   = accept && hit && (op == OP_DELETE) && (match_idx == IDX_W'(i));
            clr_ref_vec[i] = scan && ref_vec[hand] && (hand == IDX_W'(i));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        sc_key_entry #(
            .KEY_WIDTH (KEY_WIDTH)
        ) u_entry (
            .clk        (clk),
            .reset      (reset),
            .write      (wr_vec[g]),
            .set_ref    (set_ref_vec[g]),
            .clr_ref    (clr_ref_vec[g]),
            .invalidate (inval_vec[g]),
            .wr_key     (wr_key),
            .cmp_key    (cmd_key),
            .match_c    (match_vec[g]),
            .ref_bit    (ref_vec[g]),
            .valid      (valid_vec[g]),
            .key        (key_arr[g])
        );
    end

    // Controller: accept in IDLE, sweep the clock hand in SCAN, pulse response in RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
            hand      <= '0;
            key_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (accept) begin
                        key_q     <= cmd_key;
                        cmd_ready <= 1'b0;
                        if ((op == OP_INSERT) && !hit && !free_any) begin
                            state <= SCAN;
                        end else begin
                            state           <= RESP;
                            rsp_valid       <= 1'b1;
                            rsp_q.hit       <= hit;
                            rsp_q.idx       <= hit ? MAX_IDX_W'(match_idx) :
                                               (op == OP_INSERT) ? MAX_IDX_W'(free_idx) : '0;
                            rsp_q.evict     <= 1'b0;
                            rsp_q.evict_key <= '0;
                        end
                    end
                end
                SCAN: begin
                    hand <= hand_next;
                    if (!ref_vec[hand]) begin
                        state           <= RESP;
                        rsp_valid       <= 1'b1;
                        rsp_q.hit       <= 1'b0;
                        rsp_q.idx       <= MAX_IDX_W'(hand);
                        rsp_q.evict     <= 1'b1;
                        rsp_q.evict_key <= MAX_KEY_W'(key_arr[hand]);
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign rsp_hit       = rsp_q.hit;
    assign rsp_idx       = IDX_W'(rsp_q.idx);
    assign rsp_evict     = rsp_q.evict;
    assign rsp_evict_key = KEY_WIDTH'(rsp_q.evict_key);

endmodule

// File: tb/tb_sc_key_store.sv
// tb_sc_key_store: directed vector table, reset-during-scan sequence and
// randomized commands checked against an array-based second-chance model.
module tb_sc_key_store;

    localparam int unsigned KW = 8;
    localparam int unsigned DP = 4;
    localparam int unsigned IW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [KW-1:0] cmd_key;
    logic          rsp_valid;
    logic          rsp_hit;
    logic [IW-1:0] rsp_idx;
    logic          rsp_evict;
    logic [KW-1:0] rsp_evict_key;
    logic          full;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sc_key_store #(
        .KEY_WIDTH (KW),
        .DEPTH     (DP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_key       (cmd_key),
        .rsp_valid     (rsp_valid),
        .rsp_hit       (rsp_hit),
        .rsp_idx       (rsp_idx),
        .rsp_evict     (rsp_evict),
        .rsp_evict_key (rsp_evict_key),
        .full          (full)
    );

    typedef struct {
        logic [1:0]    op;
        logic [KW-1:0] key;
        logic          hit;
        logic [IW-1:0] idx;
        logic          ev;
        logic [KW-1:0] ek;
        int            lat;
        logic          full;
    } vec_t;

    vec_t tbl [20];

    // Behavioural model state
    logic [KW-1:0] m_key [DP];
    bit            m_val [DP];
    bit            m_ref [DP];
    int            m_hand;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DP; i++) begin
            m_key[i] = '0;
            m_val[i] = 1'b0;
            m_ref[i] = 1'b0;
        end
        m_hand = 0;
    endtask

    task automatic model_exec(input logic [1:0] op_raw, input logic [KW-1:0] key,
                              output logic hit, output logic [IW-1:0] idx, output logic ev,
                              output logic [KW-1:0] ek, output int lat, output logic full_o);
        int m;
        int f;
        logic [1:0] op;
        m   = -1;
        f   = -1;
        op  = (op_raw == 2'd3) ? 2'd0 : op_raw;
        hit = 1'b0;
        idx = '0;
        ev  = 1'b0;
        ek  = '0;
        lat = 1;
        for (int i = 0; i < DP; i++) begin
            if (m < 0 && m_val[i] && m_key[i] == key) m = i;
            if (f < 0 && !m_val[i]) f = i;
        end
        if (m >= 0) begin
            hit = 1'b1;
            idx = IW'(m);
            if (op == 2'd2) begin
                m_val[m] = 1'b0;
                m_ref[m] = 1'b0;
            end else begin
                m_ref[m] = 1'b1;
            end
        end else if (op == 2'd1) begin
            if (f >= 0) begin
                m_key[f] = key;
                m_val[f] = 1'b1;
                m_ref[f] = 1'b0;
                idx      = IW'(f);
            end else begin
                // Each examined entry costs one cycle; response follows the victim.
                for (int s = 0; s <= DP; s++) begin
                    lat++;
                    if (m_ref[m_hand]) begin
                        m_ref[m_hand] = 1'b0;
                        m_hand = (m_hand + 1) % DP;
                    end else begin
                        ev             = 1'b1;
                        ek             = m_key[m_hand];
                        m_key[m_hand]  = key;
                        idx            = IW'(m_hand);
                        m_hand         = (m_hand + 1) % DP;
                        break;
                    end
                end
            end
        end
        full_o = 1'b1;
        for (int i = 0; i < DP; i++) if (!m_val[i]) full_o = 1'b0;
    endtask

    // Issue one command, measure latency to rsp_valid and capture the response.
    task automatic do_cmd(input logic [1:0] op, input logic [KW-1:0] key, input bit junk,
                          output logic hit, output logic [IW-1:0] idx, output logic ev,
                          output logic [KW-1:0] ek, output int lat, output logic full_o);
        int  w;
        bit  got;
        w   = 0;
        got = 1'b0;
        hit = 1'bx;
        idx = 'x;
        ev  = 1'bx;
        ek  = 'x;
        full_o = 1'bx;
        while (cmd_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_wait: cmd_ready=%b, expected 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_key   = key;
        @(posedge clk);
        lat = 0;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (rsp_valid === 1'b1) begin
                got       = 1'b1;
                hit       = rsp_hit;
                idx       = rsp_idx;
                ev        = rsp_evict;
                ek        = rsp_evict_key;
                full_o    = full;
                cmd_valid = 1'b0;
                chk("ready_low_in_rsp", 32'(cmd_ready), 32'd0);
                break;
            end
            // Commands offered while busy must be ignored.
            if (junk) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op    = 2'($urandom);
                cmd_key   = KW'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            cmd_valid = 1'b0;
            $display("FAIL rsp_timeout: no rsp_valid within %0d cycles, expected one", lat);
        end
        @(negedge clk);
        chk("ready_return", 32'(cmd_ready), 32'd1);
        chk("rsp_single_pulse", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic          g_hit, e_hit, g_ev, e_ev, g_full, e_full;
        logic [IW-1:0] g_idx, e_idx;
        logic [KW-1:0] g_ek, e_ek;
        int            g_lat, e_lat;

        //         op     key    hit   idx   ev    ek     lat full
        tbl[0]  = '{2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 1, 1'b0};
        tbl[1]  = '{2'd1, 8'h11, 1'b0, 2'd0, 1'b0, 8'h00, 1, 1'b0};
        tbl[2]  = '{2'd1, 8'h22, 1'b0, 2'd1, 1'b0, 8'h00, 1, 1'b0};
        tbl[3]  = '{2'd1, 8'h33, 1'b0, 2'd2, 1'b0, 8'h00, 1, 1'b0};
        tbl[4]  = '{2'd1, 8'h44, 1'b0, 2'd3, 1'b0, 8'h00, 1, 1'b1};
        tbl[5]  = '{2'd0, 8'h22, 1'b1, 2'd1, 1'b0, 8'h00, 1, 1'b1};
        tbl[6]  = '{2'd1, 8'h55, 1'b0, 2'd0, 1'b1, 8'h11, 2, 1'b1};
        tbl[7]  = '{2'd0, 8'h22, 1'b1, 2'd1, 1'b0, 8'h00, 1, 1'b1};
        tbl[8]  = '{2'd0, 8'h33, 1'b1, 2'd2, 1'b0, 8'h00, 1, 1'b1};
        tbl[9]  = '{2'd0, 8'h44, 1'b1, 2'd3, 1'b0, 8'h00, 1, 1'b1};
        tbl[10] = '{2'd0, 8'h55, 1'b1, 2'd0, 1'b0, 8'h00, 1, 1'b1};
        tbl[11] = '{2'd1, 8'h66, 1'b0, 2'd1, 1'b1, 8'h22, 6, 1'b1};
        tbl[12] = '{2'd2, 8'h33, 1'b1, 2'd2, 1'b0, 8'h00, 1, 1'b0};
        tbl[13] = '{2'd1, 8'h77, 1'b0, 2'd2, 1'b0, 8'h00, 1, 1'b1};
        tbl[14] = '{2'd2, 8'h99, 1'b0, 2'd0, 1'b0, 8'h00, 1, 1'b1};
        tbl[15] = '{2'd0, 8'h55, 1'b1, 2'd0, 1'b0, 8'h00, 1, 1'b1};
        tbl[16] = '{2'd0, 8'h66, 1'b1, 2'd1, 1'b0, 8'h00, 1, 1'b1};
        tbl[17] = '{2'd0, 8'h77, 1'b1, 2'd2, 1'b0, 8'h00, 1, 1'b1};
        tbl[18] = '{2'd0, 8'h44, 1'b1, 2'd3, 1'b0, 8'h00, 1, 1'b1};
        tbl[19] = '{2'd3, 8'h66, 1'b1, 2'd1, 1'b0, 8'h00, 1, 1'b1};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_key   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_hit", 32'(rsp_hit), 32'd0);
        chk("rst_rsp_idx", 32'(rsp_idx), 32'd0);
        chk("rst_rsp_evict", 32'(rsp_evict), 32'd0);
        chk("rst_rsp_evict_key", 32'(rsp_evict_key), 32'd0);
        chk("rst_full", 32'(full), 32'd0);

        for (int i = 0; i < 20; i++) begin
            do_cmd(tbl[i].op, tbl[i].key, 1'b0, g_hit, g_idx, g_ev, g_ek, g_lat, g_full);
            chk($sformatf("vec%0d_hit", i), 32'(g_hit), 32'(tbl[i].hit));
            chk($sformatf("vec%0d_idx", i), 32'(g_idx), 32'(tbl[i].idx));
            chk($sformatf("vec%0d_evict", i), 32'(g_ev), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_evict_key", i), 32'(g_ek), 32'(tbl[i].ek));
            chk($sformatf("vec%0d_latency", i), 32'(g_lat), 32'(tbl[i].lat));
            chk($sformatf("vec%0d_full", i), 32'(g_full), 32'(tbl[i].full));
        end

        // All refs set: INSERT 0x88 starts a long scan; reset lands at T+3.
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_key   = 8'h88;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("scan_t1_no_rsp", 32'(rsp_valid), 32'd0);
        chk("scan_t1_not_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("scan_t2_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("scan_t3_no_rsp", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_full", 32'(full), 32'd0);
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("post_rst_quiet%0d", c), 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        do_cmd(2'd0, 8'h55, 1'b0, g_hit, g_idx, g_ev, g_ek, g_lat, g_full);
        chk("post_rst_lookup_hit", 32'(g_hit), 32'd0);
        chk("post_rst_lookup_idx", 32'(g_idx), 32'd0);
        chk("post_rst_lookup_full", 32'(g_full), 32'd0);

        // Randomized traffic from the freshly reset state.
        model_reset();
        for (int n = 0; n < 300; n++) begin
            logic [1:0]    op;
            logic [KW-1:0] key;
            bit            junk;
            op   = 2'($urandom_range(0, 3));
            key  = KW'($urandom_range(0, 7));
            junk = 1'($urandom_range(0, 1));
            model_exec(op, key, e_hit, e_idx, e_ev, e_ek, e_lat, e_full);
            do_cmd(op, key, junk, g_hit, g_idx, g_ev, g_ek, g_lat, g_full);
            chk($sformatf("rnd%0d_hit", n), 32'(g_hit), 32'(e_hit));
            chk($sformatf("rnd%0d_idx", n), 32'(g_idx), 32'(e_idx));
            chk($sformatf("rnd%0d_evict", n), 32'(g_ev), 32'(e_ev));
            chk($sformatf("rnd%0d_evict_key", n), 32'(g_ek), 32'(e_ek));
            chk($sformatf("rnd%0d_latency", n), 32'(g_lat), 32'(e_lat));
            chk($sformatf("rnd%0d_full", n), 32'(g_full), 32'(e_full));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sc_key_store.md
Name: sc_key_store

Overview:
- DEPTH-entry fully associative key store with second-chance (clock) replacement; each entry holds key, valid bit and reference bit.
- Serves LOOKUP, INSERT and DELETE commands over one valid/ready command port; one response per accepted command.
- Sits in front of the second-chance hash table value RAM. rsp_idx addresses the value RAM.

Parameters:
- KEY_WIDTH, 32, key bits per entry.
- DEPTH, 8, entry count, >=2, not required to be a power of two.
- IDX_W, $clog2(DEPTH), derived index width; not overridden.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  0=LOOKUP, 1=INSERT, 2=DELETE, 3=reserved (treated as LOOKUP).
- cmd_key  in  KEY_WIDTH  command key.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_hit  out  1  key was present before the command.
- rsp_idx  out  IDX_W  entry index touched (0 on DELETE/LOOKUP miss).
- rsp_evict  out  1  INSERT replaced a valid entry.
- rsp_evict_key  out  KEY_WIDTH  key that was evicted; 0 when rsp_evict=0.
- full  out  1  all entries valid (combinational from valid bits).

Behaviour:
- Reset values:
  - all valid=0, ref=0, key=0; hand=0; state IDLE.
  - cmd_ready=1, rsp_valid=0, rsp_hit=0, rsp_idx=0, rsp_evict=0, rsp_evict_key=0, full=0.
- Match rule: an entry matches only when valid=1 and its key equals cmd_key. Invalid entries never match, including key 0.
- States: IDLE, RESP, SCAN.
- A command is accepted in cycle T when cmd_valid && cmd_ready. Key and op are latched at T.
- All match/free decisions at T use pre-T contents.
- LOOKUP:
  - response at T+1.
  - hit: rsp_hit=1, rsp_idx=matching index, entry ref set to 1.
  - miss: rsp_hit=0, rsp_idx=0, no state change.
- DELETE:
  - response at T+1.
  - hit: valid=0 and ref=0 for that entry; rsp_idx=that index.
  - miss: rsp_hit=0, no change.
  - hand never moves.
- INSERT, key present: response at T+1, rsp_hit=1, ref set to 1, key not rewritten.
- INSERT, key absent with a free entry:
  - writes the lowest-index free entry with valid=1, ref=0.
  - response at T+1: rsp_hit=0, rsp_evict=0.
  - hand unchanged.
- INSERT, key absent and full:
  - go to SCAN at T+1; each SCAN cycle examines entry[hand].
  - ref=1: clear ref, hand=hand+1 with wrap DEPTH-1->0.
  - ref=0:
    - overwrite key, ref=0, valid stays 1; hand advances with wrap.
    - rsp_valid next cycle with rsp_evict=1, rsp_evict_key=old key, rsp_idx=victim.
  - Worst case (all ref=1): response at T+DEPTH+2.
- Multiple matches cannot occur. If they do, the lowest index wins.
- cmd_ready=0 from T+1 until the response cycle. It returns high in the cycle after rsp_valid.
- cmd_valid while not ready is ignored, with no side effects.
- Reset mid-SCAN or mid-RESP:
  - returns to reset values next cycle.
  - no response is emitted for the interrupted command.
- full updates the cycle after a write or delete.

Decomposition:
- Package sc_key_pkg:
  - op_e enum (OP_LOOKUP, OP_INSERT, OP_DELETE).
  - state_e enum (IDLE, RESP, SCAN).
  - response struct (hit, idx, evict, evict_key).
- Sub-module sc_key_entry:
  - one entry register: key, valid, ref.
  - inputs: write, set_ref, clr_ref, invalidate.
  - outputs: match and ref, combinational.
  - instantiated DEPTH times by generate.
- Top holds the FSM, hand counter, lowest-free and first-match priority encoders, and response registers.

Test Plan:
- DEPTH=4, KEY_WIDTH=8 for all scenarios.
- After reset, LOOKUP 0x00 -> T+1 rsp_hit=0, rsp_idx=0, full=0.
- INSERT 0x11,0x22,0x33,0x44 back-to-back -> each response at T+1 with hit=0, evict=0, idx 0,1,2,3; full=1 after the fourth.
- LOOKUP 0x22 (ref idx1=1), then INSERT 0x55 -> SCAN hand=0 ref=0 -> rsp at T+2: evict=1, evict_key=0x11, idx=0; hand=1.
- From there, LOOKUP 0x22, 0x33, 0x44, 0x55 (all ref=1), then INSERT 0x66 -> rsp at T+6: idx=1, evict_key=0x22; all other refs cleared.
- DELETE 0x33 -> hit=1, idx=2, full=0. INSERT 0x77 -> T+1 idx=2, evict=0. DELETE 0x99 -> hit=0, no change.
- INSERT 0x88 with all ref=1, assert reset at T+3 -> no rsp_valid; cmd_ready=1 next cycle; LOOKUP 0x55 misses; full=0.
